// File: rtl/cmos_pixel_capture.sv
// Capture engine for an 8-bit CMOS byte stream: pairs bytes into pixels and issues frame-buffer writes.
// Define CAPTURE_DECIMATE_EN to build the 2:1 horizontal/vertical decimation path.
module cmos_pixel_capture #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int ADDR_WIDTH = $clog2(H_ACTIVE * V_ACTIVE),
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cam_valid_i,
    input  logic                  vsync_cmos_i,
    input  logic                  href_cmos_i,
    input  logic [7:0]            pixel_data_cmos_i,
    input  logic [1:0]            mode_i,
    input  logic                  capture_en_i,
    input  logic                  single_i,
    input  logic                  decim_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  overflow_o,
    output logic                  line_err_o
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SYNC_WAIT  = 3'd1;
    localparam logic [2:0] S_FRAME_WAIT = 3'd2;
    localparam logic [2:0] S_ACTIVE     = 3'd3;
    localparam logic [2:0] S_HOLD       = 3'd4;

    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam logic [COL_W-1:0] H_LIM = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] V_LIM = ROW_W'(V_ACTIVE);

    logic [2:0]            state_q, state_d;
    logic                  href_q, vsync_q;
    logic [1:0]            mode_q, mode_d;
    logic                  phase_q, phase_d;
    logic [7:0]            b0_q, b0_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [AW1-1:0]        row_base_q, row_base_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  lerr_q, lerr_d;

    logic href_rise, href_fall, vs_rise, vs_fall;
    logic frame_start, line_end, byte_take, byte_phase, pix_done;
    logic line_skip, pix_skip;

    assign href_rise   = href_cmos_i & ~href_q;
    assign href_fall   = ~href_cmos_i & href_q;
    assign vs_rise     = vsync_cmos_i & ~vsync_q;
    assign vs_fall     = ~vsync_cmos_i & vsync_q;
    assign frame_start = (state_q == S_FRAME_WAIT) & vs_fall;
    assign line_end    = (state_q == S_ACTIVE) & href_fall;
    assign byte_take   = (state_q == S_ACTIVE) & cam_valid_i & href_cmos_i;
    // A byte arriving with the href rising edge always starts a new pixel.
    assign byte_phase  = href_rise ? 1'b0 : phase_q;
    assign pix_done    = byte_take & byte_phase;

    function automatic logic [DATA_WIDTH-1:0] fmt_pixel(input logic [1:0] mode,
                                                         input logic [7:0] b0,
                                                         input logic [7:0] b1);
        case (mode)
            2'b01:   return DATA_WIDTH'({b0, b1});
            2'b10:   return DATA_WIDTH'({b0[7:4], b0[7:4], b0[7:4]});
            default: return DATA_WIDTH'({b0[7:4], b0[2:0], b1[7], b1[4:1]});
        endcase
    endfunction

`ifdef CAPTURE_DECIMATE_EN
    logic decim_q, decim_d, line_odd_q, line_odd_d, pix_odd_q, pix_odd_d;

    always_comb begin
        decim_d    = decim_q;
        line_odd_d = line_odd_q;
        pix_odd_d  = pix_odd_q;
        if (frame_start) begin
            decim_d    = decim_i;
            line_odd_d = 1'b0;
            pix_odd_d  = 1'b0;
        end else begin
            if (line_end) line_odd_d = ~line_odd_q;
            if (href_rise) pix_odd_d = 1'b0;
            else if (pix_done) pix_odd_d = ~pix_odd_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            decim_q    <= 1'b0;
            line_odd_q <= 1'b0;
            pix_odd_q  <= 1'b0;
        end else begin
            decim_q    <= decim_d;
            line_odd_q <= line_odd_d;
            pix_odd_q  <= pix_odd_d;
        end
    end

    assign line_skip = decim_q & line_odd_q;
    assign pix_skip  = decim_q & pix_odd_q;
`else
    logic decim_unused;
    assign decim_unused = decim_i;
    assign line_skip    = 1'b0;
    assign pix_skip     = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        phase_d    = phase_q;
        b0_d       = b0_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        lerr_d     = lerr_q;

        if (byte_take) begin
            phase_d = ~byte_phase;
            if (!byte_phase) b0_d = pixel_data_cmos_i;
        end else if (href_rise) begin
            phase_d = 1'b0;
        end
        if (href_rise) col_d = '0;

        if (pix_done && !line_skip && !pix_skip) begin
            if (col_q >= H_LIM) lerr_d = 1'b1;
            else                col_d  = col_q + COL_W'(1);
            if (row_q >= V_LIM) ovf_d  = 1'b1;
            if (col_q < H_LIM && row_q < V_LIM) begin
                we_d    = 1'b1;
                waddr_d = ADDR_WIDTH'(row_base_q + AW1'(col_q));
                wdata_d = fmt_pixel(mode_q, b0_q, pixel_data_cmos_i);
            end
        end

        if (line_end) begin
            if (phase_q) lerr_d = 1'b1;
            col_d = '0;
            // row and row_base stop at the bottom of the buffer so the address never wraps
            if (!line_skip && row_q < V_LIM) begin
                row_d      = row_q + ROW_W'(1);
                row_base_d = row_base_q + AW1'(H_ACTIVE);
            end
        end

        case (state_q)
            S_IDLE:       if (capture_en_i) state_d = S_SYNC_WAIT;
            S_SYNC_WAIT:  if (vsync_cmos_i) state_d = S_FRAME_WAIT;
            S_FRAME_WAIT: begin
                if (vs_fall) begin
                    state_d    = S_ACTIVE;
                    mode_d     = mode_i;
                    phase_d    = 1'b0;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = '0;
                    ovf_d      = 1'b0;
                    lerr_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (vs_rise) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    if (single_i)          state_d = S_HOLD;
                    else if (capture_en_i) state_d = S_SYNC_WAIT;
                    else                   state_d = S_IDLE;
                end
            end
            S_HOLD:       if (!capture_en_i) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state_q    <= S_IDLE;
            href_q     <= 1'b0;
            vsync_q    <= 1'b0;
            mode_q     <= 2'b00;
            phase_q    <= 1'b0;
            b0_q       <= 8'h00;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            lerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            href_q     <= href_cmos_i;
            vsync_q    <= vsync_cmos_i;
            mode_q     <= mode_d;
            phase_q    <= phase_d;
            b0_q       <= b0_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            lerr_q     <= lerr_d;
        end
    end

    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign overflow_o   = ovf_q;
    assign line_err_o   = lerr_q;
endmodule

// File: doc/cmos_pixel_capture.md
# cmos_pixel_capture

Parametrised, single-clock capture engine for an 8-bit CMOS camera byte stream. Reassembles byte pairs into pixels in one of three selectable formats and generates row/column-addressed frame-buffer writes. Adds per-frame mode latching, optional 2:1 decimation, single-shot capture, and line/frame error detection. Sits between the camera input synchroniser (which supplies a one-cycle byte strobe in `clk_i`) and the frame-buffer RAM write port.

## Interface
- `H_ACTIVE`, 320: pixels written per line.
- `V_ACTIVE`, 240: lines written per frame.
- `ADDR_WIDTH`, $clog2(H_ACTIVE*V_ACTIVE): width of the write address.
- `DATA_WIDTH`, 12: written pixel width; legal range 12..16.

Ports:
- `clk_i` in 1: system clock. All logic is in this single clock domain.
- `reset_i` in 1: asynchronous reset, active-high.
- `cam_valid_i` in 1: one-cycle strobe; the byte on `pixel_data_cmos_i` is valid this cycle.
- `vsync_cmos_i` in 1: frame sync. High means vertical blanking.
- `href_cmos_i` in 1: line valid.
- `pixel_data_cmos_i` in 8: camera byte.
- `mode_i` in 2: pixel format. 00 = RGB565→RGB444; 01 = RGB565 raw; 10 = Y of YUV422; 11 is treated as 00.
- `capture_en_i` in 1: arms capture.
- `single_i` in 1: single-shot mode.
- `decim_i` in 1: 2:1 horizontal and vertical decimation (see Configuration).
- `we_o` out 1: RAM write enable.
- `waddr_o` out ADDR_WIDTH: RAM write address.
- `wdata_o` out DATA_WIDTH: RAM write data.
- `busy_o` out 1: a frame is being captured.
- `frame_done_o` out 1: one-cycle pulse at the end of a frame.
- `overflow_o` out 1: sticky; a pixel fell outside the V_ACTIVE rows.
- `line_err_o` out 1: sticky; a line had an odd byte count or more than H_ACTIVE pixels.

## Operation
- States: IDLE, SYNC_WAIT, FRAME_WAIT, ACTIVE, HOLD.
- IDLE → SYNC_WAIT when `capture_en_i`=1.
- SYNC_WAIT → FRAME_WAIT when `vsync_cmos_i`=1. Capture never starts mid-frame.
- FRAME_WAIT → ACTIVE on the falling edge of vsync. On this transition:
  - `mode_i` and `decim_i` are latched.
  - `row`, `col`, byte phase, `overflow_o` and `line_err_o` are cleared.
  - `busy_o` is set.
- ACTIVE → end of frame on the rising edge of vsync, including mid-line:
  - `frame_done_o` pulses and `busy_o` clears.
  - Any partial pixel is discarded.
  - Next state is HOLD if `single_i`=1, else SYNC_WAIT if `capture_en_i`=1, else IDLE.
- `capture_en_i` deasserting mid-frame does not abort; the current frame completes.
- HOLD → IDLE once `capture_en_i`=0.
- Byte phase:
  - Cleared on the rising edge of href.
  - Toggles on each `cam_valid_i` while href=1.
  - Phase 0 stores byte b0; phase 1 (byte b1) completes a pixel.
- Pixel formats:
  - Mode 00: {b0[7:4], b0[2:0], b1[7], b1[4:1]}, zero-extended to DATA_WIDTH.
  - Mode 01: {b0, b1}, keeping the DATA_WIDTH least-significant bits.
  - Mode 10: Y = b0, written as {Y[7:4], Y[7:4], Y[7:4]}, zero-extended.
- Address:
  - `waddr_o` = row_base + col.
  - row_base advances by H_ACTIVE on each falling edge of href, only for lines that are written.
  - Address arithmetic is done in ADDR_WIDTH+1 bits; no wrap-around.
- Decimation on: only even-indexed pixels and even-indexed lines are written.
- Pixel with col ≥ H_ACTIVE: dropped and `line_err_o` set.
- Pixel with row ≥ V_ACTIVE: dropped and `overflow_o` set.
- Falling edge of href with byte phase = 1: `line_err_o` set.
- Both sticky flags clear only at the next frame start or on reset.

## Timing
- Reset: all outputs are 0, state is IDLE, all counters are 0.
- Write latency: `we_o`, `waddr_o` and `wdata_o` are registered and appear 1 cycle after the `cam_valid_i` carrying b1.
- `we_o` is high for exactly 1 cycle per pixel.
- `cam_valid_i` may be asserted on back-to-back cycles.
- Edge detection uses a registered copy of href/vsync. Edges are therefore acted on 1 cycle after the input changes.
- A byte strobe in the same cycle as the href rising edge is taken as phase 0.
- If a vsync rise coincides with the cycle a pixel completes, the write is still issued and `frame_done_o` pulses in the same cycle as that `we_o`.
- `frame_done_o` lasts 1 cycle. `busy_o` falls in the same cycle.
- Reset asserted mid-frame: immediate return to IDLE with no further writes. After release, capture resumes only after a full SYNC_WAIT → FRAME_WAIT sequence.

## Configuration
- `CAPTURE_DECIMATE_EN` defined: decimation logic is built and `decim_i` is honoured (for example, a 640×480 sensor fills a 320×240 buffer).
- Not defined: `decim_i` is ignored and treated as 0, the latch and skip logic are absent, and every pixel and line is eligible for writing.

## Test plan
- Normal frame, H_ACTIVE=4, V_ACTIVE=2, mode 00: 2 lines of 8 bytes, all pairs 0xF8,0x1F → 8 writes, addresses 0..7, data 0xF0F each; `frame_done_o` pulses once.
- Mode 10, byte pair (0xA5, 0x80) → `wdata_o`=0xAAA. Mode 01 with DATA_WIDTH=16, pair (0x12, 0x34) → 0x1234.
- Errors:
  - 7-byte line → 3 writes and `line_err_o`=1.
  - 3rd line when V_ACTIVE=2 → no writes and `overflow_o`=1.
  - Both flags clear at the next vsync fall.
- `CAPTURE_DECIMATE_EN` defined, `decim_i`=1, H_ACTIVE=2, V_ACTIVE=1: 2 lines of 4 pixels → writes only pixels 0 and 2 of line 0, at addresses 0 and 1.
- Single-shot: `single_i`=1 across 2 frames → writes only in frame 1; state stays HOLD until `capture_en_i`=0.
- Enable mid-frame: `capture_en_i` rises while vsync=0 and href active → no writes until vsync has risen and fallen.
- Reset mid-line: all outputs read 0 on the next cycle.
